// File: rtl/cb_mem_bank_loader.sv
// -----------------------------------------------------------------------------
// cb_mem_bank_loader
//
// Purpose:
//   Sequences configuration writes into one connection-block memory bank. Each
//   accepted (address, data) word from the upstream bitstream streamer becomes
//   one single-bit write: address/data_in are latched, held stable for
//   SETUP_CYC cycles, enable pulses for exactly one cycle, then address/data_in
//   are held for HOLD_CYC more cycles before the next word is accepted.
//   Committed writes are counted (saturating), completion is flagged, and
//   words whose decoder field is outside 0..NUM_MEMS-1 are dropped and flagged.
//
// Ports:
//   prog_clk    - configuration clock
//   pReset      - asynchronous active-high reset
//   clear       - synchronous clear/abort
//   cfg_valid   - upstream word valid
//   cfg_ready   - loader can accept a word (IDLE and not clearing)
//   cfg_addr    - word address, [0:ADDR_W-1]; [WORD_W:ADDR_W-1] is the decoder
//                 field with cfg_addr[WORD_W] as its MSB
//   cfg_data    - bit to write
//   enable      - single-cycle write strobe to the block decoder enable
//   address     - registered address to the connection block
//   data_in     - registered data bit to the connection block
//   busy        - high in any state other than IDLE
//   write_count - committed writes, saturating at TOTAL_BITS
//   cfg_done    - sticky, high once write_count reaches TOTAL_BITS
//   err_addr    - sticky, a word with an out-of-range decoder field arrived
// -----------------------------------------------------------------------------
module cb_mem_bank_loader #(
  parameter int ADDR_W     = 7,
  parameter int WORD_W     = 3,
  parameter int NUM_MEMS   = 11,
  parameter int TOTAL_BITS = 58,
  parameter int SETUP_CYC  = 1,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [0:ADDR_W-1] cfg_addr,
  input  logic              cfg_data,
  output logic              enable,
  output logic [0:ADDR_W-1] address,
  output logic              data_in,
  output logic              busy,
  output logic [CNT_W-1:0]  write_count,
  output logic              cfg_done,
  output logic              err_addr
);

  localparam int DEC_W    = ADDR_W - WORD_W;
  localparam int MAX_WAIT = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int TMR_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [31:0]      NUM_MEMS_U = NUM_MEMS;
  localparam logic [CNT_W-1:0] TOTAL_CNT  = CNT_W'(TOTAL_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [TMR_W-1:0]   r_timer;
  logic               r_enable;
  logic [0:ADDR_W-1]  r_address;
  logic               r_dataIn;
  logic [CNT_W-1:0]   r_writeCount;
  logic               r_cfgDone;
  logic               r_errAddr;

  logic [DEC_W-1:0]   w_decField;
  logic               w_inRange;
  logic               w_transfer;
  logic               w_accept;
  logic               w_reject;
  logic               w_setupDone;
  logic               w_holdDone;

  // The ascending slice lands with cfg_addr[WORD_W] in the MSB position.
  assign w_decField  = cfg_addr[WORD_W:ADDR_W-1];
  assign w_inRange   = ({{(32-DEC_W){1'b0}}, w_decField} < NUM_MEMS_U);
  assign cfg_ready   = (r_state == ST_IDLE) & ~clear;
  assign busy        = (r_state != ST_IDLE);
  assign w_transfer  = cfg_valid & cfg_ready;
  assign w_accept    = w_transfer & w_inRange;
  assign w_reject    = w_transfer & ~w_inRange;
  assign w_setupDone = (r_timer == TMR_W'(SETUP_CYC - 1));
  assign w_holdDone  = (r_timer == TMR_W'(HOLD_CYC - 1));

  assign enable      = r_enable;
  assign address     = r_address;
  assign data_in     = r_dataIn;
  assign write_count = r_writeCount;
  assign cfg_done    = r_cfgDone;
  assign err_addr    = r_errAddr;

  // State register plus the dwell timer; the timer restarts on every state
  // change so it measures cycles spent in SETUP or HOLD.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_timer <= '0;
      end else if ((r_state == ST_SETUP) || (r_state == ST_HOLD)) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // clear aborts only from SETUP; once the strobe is due the sequence is
  // allowed to finish so the block never sees a torn write.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nextState = ST_SETUP;
      ST_SETUP: begin
        if (clear) begin
          w_nextState = ST_IDLE;
        end else if (w_setupDone) begin
          w_nextState = ST_WRITE;
        end
      end
      ST_WRITE: w_nextState = ST_HOLD;
      ST_HOLD:  if (w_holdDone) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Registered strobe and write port. address/data_in only load on an
  // accepted word, so they keep the last written value while idle.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_enable  <= 1'b0;
      r_address <= '0;
      r_dataIn  <= 1'b0;
    end else begin
      r_enable <= (w_nextState == ST_WRITE);
      if (w_accept) begin
        r_address <= cfg_addr;
        r_dataIn  <= cfg_data;
      end
    end
  end

  // Status: clear wins over both the commit increment and the error flag.
  // A write cut short by clear is therefore never left in the count.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_writeCount <= '0;
      r_cfgDone    <= 1'b0;
      r_errAddr    <= 1'b0;
    end else if (clear) begin
      r_writeCount <= '0;
      r_cfgDone    <= 1'b0;
      r_errAddr    <= 1'b0;
    end else begin
      if ((r_state == ST_WRITE) && (r_writeCount != TOTAL_CNT)) begin
        r_writeCount <= r_writeCount + 1'b1;
        if (r_writeCount == TOTAL_CNT - 1'b1) begin
          r_cfgDone <= 1'b1;
        end
      end
      if (w_reject) begin
        r_errAddr <= 1'b1;
      end
    end
  end

endmodule
